hazard_stall_controller: RTL

Pipeline interlock and sequencing controller for the ID stage of the 5-stage MIPS core. Decides each cycle whether IF/ID advance, stall, or flush. Detects load-use hazards against the ID/EX stage, applies branch/jump flushes, and owns the multi-cycle multiply/divide (HI/LO) busy sequencer. Any mult/div or mfhi/mflo in ID is held until HI/LO is valid. Also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_stall_controller_if.sv | 31 +++
 rtl/hazard_stall_controller.sv | 48 ++++
 2 files changed

// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if: ID/EX hazard inputs and pipeline control outputs
interface hazard_stall_controller_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        id_branch_taken;
  logic        id_jump;
  logic        id_md_start;
  logic        id_md_is_div;
  logic        id_reads_hilo;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_bubble;
  logic        if_id_flush;
  logic        md_busy;
  logic        md_done;
  logic [15:0] stall_cnt;
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           id_branch_taken, id_jump, id_md_start, id_md_is_div, id_reads_hilo,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, md_busy, md_done, stall_cnt
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt,
           id_branch_taken, id_jump, id_md_start, id_md_is_div, id_reads_hilo,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: ID-stage interlock, flush control, mult/div busy sequencer
module hazard_stall_controller #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input logic clk,
  input logic rst,
  hazard_stall_controller_if.slave hz
);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      stall_q;
  logic             load_stall, md_stall, stall, busy;
  always_comb begin
    busy       = state == MD_BUSY;
    load_stall = hz.ex_mem_read & (hz.ex_rt != 5'd0) &
                 ((hz.id_uses_rs & (hz.id_rs == hz.ex_rt)) | (hz.id_uses_rt & (hz.id_rt == hz.ex_rt)));
    md_stall   = busy & (hz.id_md_start | hz.id_reads_hilo);
    stall      = load_stall | md_stall;
  end
  // reset forces the pipeline to advance with no bubble or flush
  assign hz.pc_write     = rst | ~stall;
  assign hz.if_id_write  = rst | ~stall;
  assign hz.id_ex_bubble = ~rst & stall;
  assign hz.if_id_flush  = ~rst & (hz.id_branch_taken | hz.id_jump) & ~stall;
  assign hz.md_busy      = busy;
  assign hz.md_done      = busy & (cnt == '0);
  assign hz.stall_cnt    = stall_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      stall_q <= '0;
    end else begin
      if (stall && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (state == IDLE) begin
        if (hz.id_md_start && !load_stall) begin
          state <= MD_BUSY;
          cnt   <= hz.id_md_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
        end
      end else if (cnt == '0) state <= IDLE;
      else cnt <= cnt - CNT_W'(1);
    end
  end
endmodule
